// File: rtl/store_buffer_if.sv
// Execute-stage store/load ports and data-memory write port of the store buffer.
// master = pipeline + memory side, slave = store buffer.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [5:0]    st_opcode;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_stall;
  logic          mem_valid;
  logic          mem_ready;
  logic [29:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_opcode, st_addr, st_data, ld_valid, ld_addr, mem_ready,
    input  st_ready, ld_stall, mem_valid, mem_addr, mem_wdata, mem_we, count
  );

  modport slave (
    input  st_valid, st_opcode, st_addr, st_data, ld_valid, ld_addr, mem_ready,
    output st_ready, ld_stall, mem_valid, mem_addr, mem_wdata, mem_we, count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order MIPS store buffer: lane-aligns SB/SH/SW stores, drains them to data
// memory one per handshake and stalls loads that hit a pending store word.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  logic [29:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_we   [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  logic        is_store;
  logic        st_ready_int;
  logic        mem_valid_int;
  logic        accept;
  logic        pop;
  logic [31:0] lane_data;
  logic [3:0]  lane_we;
  logic        ld_hit;
  logic [1:0]  unused_bits;

  assign unused_bits   = bus.ld_addr[1:0];
  assign is_store      = (bus.st_opcode == OP_SB) || (bus.st_opcode == OP_SH) ||
                         (bus.st_opcode == OP_SW);
  assign st_ready_int  = (cnt < (AW+1)'(DEPTH));
  assign mem_valid_int = (cnt != '0);
  assign accept        = bus.st_valid & st_ready_int & is_store;
  assign pop           = mem_valid_int & bus.mem_ready;

  // Big-endian lanes: byte offset 0 lands in bits [31:24].
  always_comb begin
    lane_we   = 4'b0000;
    lane_data = 32'h0;
    case (bus.st_opcode)
      OP_SB: begin
        lane_we   = 4'b1000 >> bus.st_addr[1:0];
        lane_data = {4{bus.st_data[7:0]}};
      end
      OP_SH: begin
        lane_we   = bus.st_addr[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{bus.st_data[15:0]}};
      end
      OP_SW: begin
        lane_we   = 4'b1111;
        lane_data = bus.st_data;
      end
      default: begin
        lane_we   = 4'b0000;
        lane_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (accept) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset; occupancy is tracked by ent_vld and cnt.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_addr[wr_ptr] <= bus.st_addr[31:2];
      ent_data[wr_ptr] <= lane_data;
      ent_we[wr_ptr]   <= lane_we;
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == bus.ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

  assign bus.st_ready  = st_ready_int;
  assign bus.mem_valid = mem_valid_int;
  assign bus.mem_addr  = mem_valid_int ? ent_addr[rd_ptr] : 30'h0;
  assign bus.mem_wdata = mem_valid_int ? ent_data[rd_ptr] : 32'h0;
  assign bus.mem_we    = mem_valid_int ? ent_we[rd_ptr]   : 4'b0000;
  assign bus.ld_stall  = bus.ld_valid & ld_hit;
  assign bus.count     = cnt;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } item_t;

  logic clk;
  logic rst;
  store_buffer_if #(.DEPTH(DEPTH)) bus ();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  item_t sb_q[$];
  int model_cnt = 0;
  bit pend = 0;
  item_t pend_item;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Reference: byte offset k (big-endian) maps to enable bit 3-k; each lane
  // carries the store value's byte selected by lane index modulo store size.
  function automatic item_t make_item(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] d);
    item_t it;
    int nbytes;
    int first;
    nbytes = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
    first  = (nbytes == 4) ? 0 : (nbytes == 2) ? (a[1] ? 2 : 0) : int'(a[1:0]);
    it.addr = a[31:2];
    it.we   = 4'b0000;
    for (int k = first; k < first + nbytes; k++) it.we[3-k] = 1'b1;
    for (int l = 0; l < 4; l++) it.data[8*l +: 8] = d[8*(l % nbytes) +: 8];
    return it;
  endfunction

  // Predictor: decides accept/pop from the model occupancy and checks status outputs.
  always @(negedge clk) begin
    if (rst) begin
      model_cnt = 0;
      pend = 0;
      sb_q.delete();
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    end else begin
      bit acc;
      bit pp;
      chk("st_ready", 32'(bus.st_ready), 32'(model_cnt < DEPTH));
      chk("count", 32'(bus.count), 32'(model_cnt));
      chk("mem_valid", 32'(bus.mem_valid), 32'(model_cnt != 0));
      acc = bus.st_valid && op_is_store(bus.st_opcode) && (model_cnt < DEPTH);
      pp  = bus.mem_ready && (model_cnt != 0);
      pend = acc;
      if (acc) pend_item = make_item(bus.st_opcode, bus.st_addr, bus.st_data);
      model_cnt = model_cnt + int'(acc) - int'(pp);
    end
  end

  always @(posedge clk) begin
    if (pend) sb_q.push_back(pend_item);
  end

  // Monitor: load-hazard check against occupied entries, then head compare/pop.
  always @(negedge clk) begin
    if (!rst) begin
      bit hit;
      hit = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].addr == bus.ld_addr[31:2]) hit = 1'b1;
      chk("ld_stall", 32'(bus.ld_stall), 32'(bus.ld_valid && hit));
      if (bus.mem_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_head", 32'(bus.mem_valid), 32'd0);
        end else begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(sb_q[0].addr));
          chk("mem_wdata", bus.mem_wdata, sb_q[0].data);
          chk("mem_we", 32'(bus.mem_we), 32'(sb_q[0].we));
          if (bus.mem_ready) void'(sb_q.pop_front());
        end
      end else begin
        chk("idle_outputs", {bus.mem_addr[27:0], bus.mem_we},
            32'(|bus.mem_wdata | |bus.mem_addr[29:28]));
      end
    end else begin
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid  = 1'b1;
    bus.st_opcode = op;
    bus.st_addr   = a;
    bus.st_data   = d;
  endtask

  initial begin
    logic [5:0] ops [5];
    ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW; ops[3] = 6'h23; ops[4] = 6'h00;
    rst = 1'b1;
    bus.st_valid = 0; bus.st_opcode = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.mem_ready = 0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("reset_st_ready", 32'(bus.st_ready), 32'd1);
    chk("reset_count", 32'(bus.count), 32'd0);

    // Byte store at offset 3 goes to the least significant lane.
    bus.mem_ready = 1'b1;
    put(OP_SB, 32'h103, 32'hAB);
    step();
    bus.st_valid = 0;
    chk("sb_mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("sb_mem_addr", 32'(bus.mem_addr), 32'h40);
    chk("sb_mem_we", 32'(bus.mem_we), 32'b0001);
    chk("sb_mem_wdata", bus.mem_wdata, 32'hABABABAB);
    step();
    chk("sb_drained", 32'(bus.count), 32'd0);

    // Halfword then word, head held while memory is busy.
    bus.mem_ready = 1'b0;
    put(OP_SH, 32'h202, 32'h1234);
    step();
    put(OP_SW, 32'h300, 32'hDEADBEEF);
    step();
    bus.st_valid = 0;
    chk("sh_count", 32'(bus.count), 32'd2);
    chk("sh_we", 32'(bus.mem_we), 32'b0011);
    chk("sh_wdata", bus.mem_wdata, 32'h12341234);
    step();
    chk("sh_hold_we", 32'(bus.mem_we), 32'b0011);
    chk("sh_hold_addr", 32'(bus.mem_addr), 32'h80);
    bus.mem_ready = 1'b1;
    step();
    chk("sw_we", 32'(bus.mem_we), 32'b1111);
    chk("sw_addr", 32'(bus.mem_addr), 32'hC0);
    step();
    chk("pair_drained", 32'(bus.count), 32'd0);

    // Fill, overflow attempt, pop while full, then wrap.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(OP_SW, 32'h1000 + 32'(4*i), 32'(i));
      step();
    end
    chk("full_st_ready", 32'(bus.st_ready), 32'd0);
    put(OP_SW, 32'h1010, 32'd4);
    step();
    chk("full_count", 32'(bus.count), 32'd4);
    bus.mem_ready = 1'b1;
    step();
    chk("pop_full_count", 32'(bus.count), 32'd3);
    chk("pop_full_ready", 32'(bus.st_ready), 32'd1);
    chk("pop_full_head", 32'(bus.mem_addr), 32'h401);
    bus.mem_ready = 1'b0;
    step();
    chk("fifth_accepted", 32'(bus.count), 32'd4);
    bus.st_valid = 0;
    bus.mem_ready = 1'b1;
    repeat (5) step();
    chk("wrap_drained", 32'(bus.count), 32'd0);

    // Load hazard on a pending word.
    bus.mem_ready = 1'b0;
    put(OP_SW, 32'h500, 32'h55);
    step();
    bus.st_valid = 0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h502;
    #1 chk("ld_hit", 32'(bus.ld_stall), 32'd1);
    bus.ld_addr = 32'h504;
    #1 chk("ld_miss", 32'(bus.ld_stall), 32'd0);
    bus.ld_addr = 32'h502;
    bus.mem_ready = 1'b1;
    #1 chk("ld_hit_popping", 32'(bus.ld_stall), 32'd1);
    step();
    chk("ld_after_pop", 32'(bus.ld_stall), 32'd0);
    bus.ld_valid = 0;

    // Reset mid-drain discards everything.
    bus.mem_ready = 1'b0;
    put(OP_SW, 32'h600, 32'h1);
    step();
    put(OP_SH, 32'h604, 32'h2);
    step();
    put(OP_SB, 32'h608, 32'h3);
    step();
    bus.st_valid = 0;
    bus.mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_async_count", 32'(bus.count), 32'd0);
    chk("rst_async_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_async_we", 32'(bus.mem_we), 32'd0);
    step();
    rst = 1'b0;
    put(OP_SW, 32'h700, 32'h77);
    bus.mem_ready = 1'b0;
    step();
    bus.st_valid = 0;
    chk("first_after_rst", 32'(bus.count), 32'd1);
    bus.mem_ready = 1'b1;
    repeat (2) step();

    // Random traffic over a small address pool so loads hit pending stores.
    for (int n = 0; n < 600; n++) begin
      bus.st_valid  = ($urandom_range(0, 3) != 0);
      bus.st_opcode = ops[$urandom_range(0, 4)];
      bus.st_addr   = 32'h2000 + 32'($urandom_range(0, 31));
      bus.st_data   = $urandom;
      bus.ld_valid  = $urandom_range(0, 1) == 1;
      bus.ld_addr   = 32'h2000 + 32'($urandom_range(0, 31));
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    bus.st_valid = 0;
    bus.ld_valid = 0;
    bus.mem_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_count", 32'(bus.count), 32'd0);
    chk("final_queue", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
